regfile_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the 8-entry x 8-bit general register file of the RNBIP-2 datapath.
- Accepts one decoded-register instruction at a time over a valid/ready handshake.
- Drives the register file's enab/mux_sel/reg_sel/seg controls, gates the ALU through a start/done handshake, and waits on the OR2 operand register when needed.
- Sits between the instruction register/decoder and the register file + ALU.

---
 rtl/regfile_sequencer_if.sv | 42 ++++
 rtl/regfile_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_if.sv
`default_nettype none
// ============================================================================
// regfile_sequencer_if : instruction, OR2, ALU and register-file control bundle
// Rev 1.0
// ============================================================================
interface regfile_sequencer_if #(
  parameter int CNT_W = 8
);

  logic [7:0]       instr;
  logic             instr_valid;
  logic             instr_ready;
  logic             or2_valid;
  logic             or2_ready;
  logic             alu_start;
  logic             alu_done;
  logic [1:0]       enab;
  logic [2:0]       mux_sel;
  logic [2:0]       reg_sel;
  logic [2:0]       seg;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] retired;

  // Sequencer side
  modport slave (
    input  instr, instr_valid, or2_valid, alu_done,
    output instr_ready, or2_ready, alu_start, enab, mux_sel, reg_sel, seg,
           busy, done, err, retired
  );

  // Decoder / datapath side
  modport master (
    output instr, instr_valid, or2_valid, alu_done,
    input  instr_ready, or2_ready, alu_start, enab, mux_sel, reg_sel, seg,
           busy, done, err, retired
  );

endinterface

`default_nettype wire

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// regfile_sequencer : multi-cycle control FSM for the RNBIP-2 8x8 register file
// Rev 1.0
// ============================================================================
module regfile_sequencer #(
  parameter int ALU_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  regfile_sequencer_if.slave bus
);

  localparam logic [2:0] C_OP_NOP    = 3'b000;
  localparam logic [2:0] C_OP_CLR    = 3'b001;
  localparam logic [2:0] C_OP_MOV_R0 = 3'b010;
  localparam logic [2:0] C_OP_MOV_RN = 3'b011;
  localparam logic [2:0] C_OP_LDI    = 3'b100;
  localparam logic [2:0] C_OP_ALU    = 3'b101;
  localparam logic [2:0] C_OP_CMP    = 3'b110;

  localparam logic [1:0] C_EN_CLEAR = 2'b00;
  localparam logic [1:0] C_EN_WRITE = 2'b01;
  localparam logic [1:0] C_EN_READ  = 2'b10;
  localparam logic [1:0] C_EN_HOLD  = 2'b11;

  localparam logic [2:0] C_SRC_R0  = 3'b000;
  localparam logic [2:0] C_SRC_RN  = 3'b001;
  localparam logic [2:0] C_SRC_OR2 = 3'b010;
  localparam logic [2:0] C_SRC_ALU = 3'b011;

  localparam logic [2:0] C_R0         = 3'b000;
  localparam logic [7:0] C_TMO_LAST   = 8'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_WAIT_OR2 = 3'd2,
    S_READ     = 3'd3,
    S_EXEC     = 3'd4,
    S_WRITE    = 3'd5,
    S_CLEAR    = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [2:0]       r_rn;
  logic [7:0]       r_tmo_cnt;
  logic [CNT_W-1:0] r_retired;
  logic             r_instr_ready;
  logic             r_or2_ready;
  logic             r_alu_start;
  logic [1:0]       r_enab;
  logic [2:0]       r_mux_sel;
  logic [2:0]       r_reg_sel;
  logic [2:0]       r_seg;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  // instr[1:0] carries no meaning for this block
  logic w_unused_instr;
  assign w_unused_instr = ^bus.instr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_rn          <= '0;
      r_tmo_cnt     <= '0;
      r_retired     <= '0;
      r_instr_ready <= 1'b1;
      r_or2_ready   <= 1'b0;
      r_alu_start   <= 1'b0;
      r_enab        <= C_EN_HOLD;
      r_mux_sel     <= C_SRC_R0;
      r_reg_sel     <= C_R0;
      r_seg         <= C_R0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // Pulses and the register-file mode fall back every cycle unless re-armed below
      r_alu_start <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_enab      <= C_EN_HOLD;

      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid && r_instr_ready) begin
            r_op          <= bus.instr[7:5];
            r_rn          <= bus.instr[4:2];
            r_state       <= S_DECODE;
            r_instr_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end

        S_DECODE: begin
          case (r_op)
            C_OP_NOP: begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
            C_OP_CLR: begin
              r_state <= S_CLEAR;
              r_enab  <= C_EN_CLEAR;
            end
            C_OP_MOV_R0: begin
              r_state   <= S_WRITE;
              r_enab    <= C_EN_WRITE;
              r_mux_sel <= C_SRC_RN;
              r_reg_sel <= r_rn;
              r_seg     <= C_R0;
            end
            C_OP_MOV_RN: begin
              r_state   <= S_WRITE;
              r_enab    <= C_EN_WRITE;
              r_mux_sel <= C_SRC_R0;
              r_seg     <= r_rn;
            end
            C_OP_LDI: begin
              r_state     <= S_WAIT_OR2;
              r_or2_ready <= 1'b1;
            end
            C_OP_ALU, C_OP_CMP: begin
              r_state <= S_READ;
              r_enab  <= C_EN_READ;
              r_seg   <= r_rn;
            end
            default: begin
              r_state       <= S_IDLE;
              r_err         <= 1'b1;
              r_instr_ready <= 1'b1;
              r_busy        <= 1'b0;
            end
          endcase
        end

        S_WAIT_OR2: begin
          if (bus.or2_valid) begin
            r_or2_ready <= 1'b0;
            r_state     <= S_WRITE;
            r_enab      <= C_EN_WRITE;
            r_mux_sel   <= C_SRC_OR2;
            r_seg       <= r_rn;
          end
        end

        S_READ: begin
          r_state     <= S_EXEC;
          r_alu_start <= 1'b1;
          r_tmo_cnt   <= '0;
        end

        S_EXEC: begin
          // alu_done is tested first so a result in the final allowed cycle still lands
          if (bus.alu_done) begin
            if (r_op == C_OP_ALU) begin
              r_state   <= S_WRITE;
              r_enab    <= C_EN_WRITE;
              r_mux_sel <= C_SRC_ALU;
              r_seg     <= C_R0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else if (r_tmo_cnt == C_TMO_LAST) begin
            r_state       <= S_IDLE;
            r_err         <= 1'b1;
            r_instr_ready <= 1'b1;
            r_busy        <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end

        S_WRITE, S_CLEAR: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end

        S_DONE: begin
          r_state       <= S_IDLE;
          r_retired     <= r_retired + CNT_W'(1);
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
        end

        default: begin
          r_state       <= S_IDLE;
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_ready = r_instr_ready;
  assign bus.or2_ready   = r_or2_ready;
  assign bus.alu_start   = r_alu_start;
  assign bus.enab        = r_enab;
  assign bus.mux_sel     = r_mux_sel;
  assign bus.reg_sel     = r_reg_sel;
  assign bus.seg         = r_seg;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.retired     = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// tb_regfile_sequencer : randomized instruction stream scored against a
// transaction-level timing model of the sequencer. Rev 1.0
// ============================================================================
module tb_regfile_sequencer;

  localparam int ALU_TIMEOUT = 4;
  localparam int CNT_W       = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [CNT_W-1:0] model_retired = '0;
  logic [CNT_W-1:0] wrap_start;

  regfile_sequencer_if #(.CNT_W(CNT_W)) bus ();

  regfile_sequencer #(
    .ALU_TIMEOUT(ALU_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Issue one instruction at an IDLE negedge; k = extra OR2 stall cycles, n = ALU delay after start
  task automatic run_instr(input logic [2:0] op, input logic [2:0] rn, input int k, input int n);
    int end_t = 0, wr_cnt = 0, wr_t = 0, clr_cnt = 0, clr_t = 0, rd_cnt = 0, rd_t = 0;
    int st_cnt = 0, st_t = 0, or2_cnt = 0, done_cnt = 0, done_t = 0, err_cnt = 0, err_t = 0;
    int bad_busy = 0;
    int wr_mux = 0, wr_reg = 0, wr_seg = 0, rd_seg = 0;
    int e_done = 0, e_err = 0, e_wr = 0, e_clr = 0, e_rd = 0, e_st = 0, e_or2 = 0, e_end;
    int e_mux = 0, e_seg = 0;
    bit alu_op;
    string p;

    p = $sformatf("op%0d/rn%0d/k%0d/n%0d", op, rn, k, n);
    alu_op = (op == 3'd5) || (op == 3'd6);

    case (op)
      3'd0: e_done = 2;
      3'd1: begin e_clr = 2; e_done = 3; end
      3'd2: begin e_wr = 2; e_mux = 1; e_seg = 0; e_done = 3; end
      3'd3: begin e_wr = 2; e_mux = 0; e_seg = int'(rn); e_done = 3; end
      3'd4: begin e_or2 = k + 1; e_wr = 3 + k; e_mux = 2; e_seg = int'(rn); e_done = 4 + k; end
      3'd5, 3'd6: begin
        e_rd = 2;
        e_st = 3;
        if (n >= ALU_TIMEOUT) e_err = 3 + ALU_TIMEOUT;
        else if (op == 3'd5) begin e_wr = 4 + n; e_mux = 3; e_seg = 0; e_done = 5 + n; end
        else e_done = 4 + n;
      end
      default: e_err = 2;
    endcase
    e_end = (e_done != 0) ? e_done + 1 : e_err;
    if (e_done != 0) model_retired = model_retired + 1'b1;

    chk_eq({p, " accept_ready"}, int'(bus.instr_ready), 1);
    bus.instr       = {op, rn, 2'($urandom)};
    bus.instr_valid = 1'b1;
    bus.or2_valid   = 1'($urandom);
    bus.alu_done    = 1'($urandom);

    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      if (bus.enab == 2'b01) begin
        wr_cnt++;
        if (wr_cnt == 1) begin
          wr_t = t; wr_mux = int'(bus.mux_sel); wr_reg = int'(bus.reg_sel); wr_seg = int'(bus.seg);
        end
      end
      if (bus.enab == 2'b00) begin clr_cnt++; if (clr_t == 0) clr_t = t; end
      if (bus.enab == 2'b10) begin rd_cnt++; if (rd_t == 0) begin rd_t = t; rd_seg = int'(bus.seg); end end
      if (bus.alu_start) begin st_cnt++; if (st_t == 0) st_t = t; end
      if (bus.or2_ready) or2_cnt++;
      if (bus.done) begin done_cnt++; if (done_t == 0) done_t = t; end
      if (bus.err) begin err_cnt++; if (err_t == 0) err_t = t; end
      if (bus.busy == bus.instr_ready) bad_busy++;
      if (bus.instr_ready) begin end_t = t; break; end
      // Noise while busy must be ignored; OR2/ALU strobes only mean something in their own windows
      bus.instr_valid = 1'($urandom);
      bus.instr       = 8'($urandom);
      bus.or2_valid   = (op == 3'd4 && t >= 2) ? (t >= 2 + k) : 1'($urandom);
      bus.alu_done    = (alu_op && t >= 3) ? (t == 3 + n) : 1'($urandom);
    end
    bus.instr_valid = 1'b0;

    chk_eq({p, " end_cycle"}, end_t, e_end);
    chk_eq({p, " done_count"}, done_cnt, (e_done != 0) ? 1 : 0);
    chk_eq({p, " done_cycle"}, done_t, e_done);
    chk_eq({p, " err_count"}, err_cnt, (e_err != 0) ? 1 : 0);
    chk_eq({p, " err_cycle"}, err_t, e_err);
    chk_eq({p, " write_count"}, wr_cnt, (e_wr != 0) ? 1 : 0);
    chk_eq({p, " write_cycle"}, wr_t, e_wr);
    if (e_wr != 0) begin
      chk_eq({p, " write_mux"}, wr_mux, e_mux);
      chk_eq({p, " write_seg"}, wr_seg, e_seg);
      if (op == 3'd2) chk_eq({p, " write_reg"}, wr_reg, int'(rn));
    end
    chk_eq({p, " clear_count"}, clr_cnt, (e_clr != 0) ? 1 : 0);
    chk_eq({p, " clear_cycle"}, clr_t, e_clr);
    chk_eq({p, " read_count"}, rd_cnt, (e_rd != 0) ? 1 : 0);
    chk_eq({p, " read_cycle"}, rd_t, e_rd);
    if (e_rd != 0) chk_eq({p, " read_seg"}, rd_seg, int'(rn));
    chk_eq({p, " start_count"}, st_cnt, (e_st != 0) ? 1 : 0);
    chk_eq({p, " start_cycle"}, st_t, e_st);
    chk_eq({p, " or2_ready_cycles"}, or2_cnt, e_or2);
    chk_eq({p, " busy_vs_ready"}, bad_busy, 0);
    chk_eq({p, " retired"}, int'(bus.retired), int'(model_retired));

    if (end_t == 0) begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_retired = '0;
    end
  endtask

  task automatic reset_mid_exec();
    chk_eq("mid_rst accept_ready", int'(bus.instr_ready), 1);
    bus.instr       = 8'hAC;
    bus.instr_valid = 1'b1;
    bus.alu_done    = 1'b0;
    bus.or2_valid   = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("mid_rst in_exec_start", int'(bus.alu_start), 1);
    #1 rst = 1'b1;
    #1;
    chk_eq("mid_rst enab", int'(bus.enab), 3);
    chk_eq("mid_rst instr_ready", int'(bus.instr_ready), 1);
    chk_eq("mid_rst busy", int'(bus.busy), 0);
    chk_eq("mid_rst retired", int'(bus.retired), 0);
    chk_eq("mid_rst alu_start", int'(bus.alu_start), 0);
    @(negedge clk);
    rst = 1'b0;
    model_retired = '0;
    for (int i = 0; i < 3; i++) begin
      bus.alu_done = 1'($urandom);
      @(negedge clk);
      chk_eq("post_rst no_write", int'(bus.enab == 2'b01), 0);
    end
    bus.alu_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.or2_valid   = 1'b0;
    bus.alu_done    = 1'b0;
    repeat (2) @(negedge clk);

    chk_eq("reset enab", int'(bus.enab), 3);
    chk_eq("reset instr_ready", int'(bus.instr_ready), 1);
    chk_eq("reset busy", int'(bus.busy), 0);
    chk_eq("reset mux_sel", int'(bus.mux_sel), 0);
    chk_eq("reset reg_sel", int'(bus.reg_sel), 0);
    chk_eq("reset seg", int'(bus.seg), 0);
    chk_eq("reset alu_start", int'(bus.alu_start), 0);
    chk_eq("reset or2_ready", int'(bus.or2_ready), 0);
    chk_eq("reset done", int'(bus.done), 0);
    chk_eq("reset err", int'(bus.err), 0);
    chk_eq("reset retired", int'(bus.retired), 0);
    rst = 1'b0;

    run_instr(3'd2, 3'd2, 0, 0);                 // 0x48 MOV R0<-R2
    run_instr(3'd5, 3'd3, 0, 2);                 // 0xAC ALU, result 2 cycles after start
    run_instr(3'd5, 3'd1, 0, 100);               // ALU that never answers
    run_instr(3'd4, 3'd5, 6, 0);                 // 0x94 LDI R5 with stalled OR2
    run_instr(3'd1, 3'd0, 0, 0);                 // CLR
    run_instr(3'd7, 3'd0, 0, 0);                 // 0xE0 illegal
    run_instr(3'd5, 3'd6, 0, ALU_TIMEOUT - 1);   // result in the last allowed cycle
    run_instr(3'd6, 3'd4, 0, ALU_TIMEOUT);       // CMP just past the limit
    run_instr(3'd6, 3'd2, 0, 0);
    run_instr(3'd3, 3'd7, 0, 0);
    run_instr(3'd0, 3'd1, 0, 0);
    reset_mid_exec();

    for (int i = 0; i < 300; i++)
      run_instr(3'($urandom), 3'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 6)));

    wrap_start = model_retired;
    for (int i = 0; i < 256; i++)
      run_instr(3'd0, 3'($urandom), 0, 0);
    chk_eq("nop_wrap retired", int'(bus.retired), int'(wrap_start));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
